// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture write path.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } cap_state_e;

  // |i|+|q| needs one bit more than the wider component.
  function automatic int mag_bits(input int i_bits, input int q_bits);
    return ((i_bits > q_bits) ? i_bits : q_bits) + 1;
  endfunction

endpackage

// File: rtl/capture_writer_if.sv
// Write channel (address/data plus write response) into the capture buffer.
interface capture_writer_if #(
  parameter int CAP_I_BITS     = 12,
  parameter int CAP_Q_BITS     = 12,
  parameter int CAP_INDEX_BITS = 10
);
  logic [CAP_INDEX_BITS-1:0]          m_axi_cap_waddr;
  logic [CAP_I_BITS+CAP_Q_BITS-1:0]   m_axi_cap_wdata;
  logic                               m_axi_cap_wvalid;
  logic                               s_axi_cap_wready;
  logic                               s_axi_cap_bvalid;
  logic                               s_axi_cap_bresp;
  logic                               m_axi_cap_bready;

  modport master (
    output m_axi_cap_waddr, m_axi_cap_wdata, m_axi_cap_wvalid, m_axi_cap_bready,
    input  s_axi_cap_wready, s_axi_cap_bvalid, s_axi_cap_bresp
  );

  modport slave (
    input  m_axi_cap_waddr, m_axi_cap_wdata, m_axi_cap_wvalid, m_axi_cap_bready,
    output s_axi_cap_wready, s_axi_cap_bvalid, s_axi_cap_bresp
  );
endinterface

// File: rtl/iq_magnitude.sv
// Combinational L1 magnitude |i|+|q| of a signed I/Q pair, unsigned result.
module iq_magnitude #(
  parameter int I_BITS   = 12,
  parameter int Q_BITS   = 12,
  parameter int MAG_BITS = 13
) (
  input  logic signed [I_BITS-1:0] i_i,
  input  logic signed [Q_BITS-1:0] i_q,
  output logic [MAG_BITS-1:0]      o_mag
);
  logic [MAG_BITS-1:0] w_abs_i;
  logic [MAG_BITS-1:0] w_abs_q;

  // Sign-extend first so the most-negative code negates to 2^(N-1) exactly.
  always_comb begin
    w_abs_i = {{(MAG_BITS-I_BITS){i_i[I_BITS-1]}}, i_i};
    w_abs_q = {{(MAG_BITS-Q_BITS){i_q[Q_BITS-1]}}, i_q};
    if (i_i[I_BITS-1]) w_abs_i = ~w_abs_i + MAG_BITS'(1);
    if (i_q[Q_BITS-1]) w_abs_q = ~w_abs_q + MAG_BITS'(1);
    o_mag = w_abs_i + w_abs_q;
  end
endmodule

// File: rtl/capture_writer.sv
// Triggered I/Q capture into the capture buffer write channel.
// Optional CAPTURE_DECIM_EN adds a decim port: keep every (decim+1)-th sample.
module capture_writer
  import capture_pkg::*;
#(
  parameter  int CAP_I_BITS        = 12,
  parameter  int CAP_Q_BITS        = 12,
  parameter  int CAP_INDEX_BITS    = 10,
  parameter  int CAP_BUFFER_LENGTH = 1024,
  parameter  int OUTSTANDING_MAX   = 4,
  localparam int MAG_BITS          = mag_bits(CAP_I_BITS, CAP_Q_BITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic                         force_trig,
  input  logic [MAG_BITS-1:0]          threshold,
  input  logic signed [CAP_I_BITS-1:0] in_i,
  input  logic signed [CAP_Q_BITS-1:0] in_q,
  input  logic                         in_valid,
  output logic                         in_ready,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]                   decim,
`endif
  capture_writer_if.master             cap,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int DATA_W = CAP_I_BITS + CAP_Q_BITS;
  localparam int OUT_W  = $clog2(OUTSTANDING_MAX + 1);
  localparam int LD_W   = $clog2(CAP_BUFFER_LENGTH + 1);
  localparam logic [OUT_W-1:0]          OUT_MAX   = OUT_W'(OUTSTANDING_MAX);
  localparam logic [LD_W-1:0]           LEN_CNT   = LD_W'(CAP_BUFFER_LENGTH);
  localparam logic [CAP_INDEX_BITS-1:0] LAST_ADDR = CAP_INDEX_BITS'(CAP_BUFFER_LENGTH - 1);

  cap_state_e                r_state;
  logic                      r_hold_valid;
  logic [CAP_INDEX_BITS-1:0] r_waddr;
  logic [DATA_W-1:0]         r_wdata;
  logic [OUT_W-1:0]          r_outst;
  logic [LD_W-1:0]           r_loaded;
  logic [7:0]                r_decim;
  logic [7:0]                r_dcnt;
  logic                      r_bready;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;

  logic [MAG_BITS-1:0] w_mag;
  logic [7:0]          w_decim;
  logic [DATA_W-1:0]   w_sample;
  logic                w_wvalid;
  logic                w_wr_acc;
  logic                w_b_acc;
  logic                w_b_dec;
  logic                w_keep;
  logic                w_trig;
  logic                w_in_ready;
  logic                w_in_acc;

  iq_magnitude #(
    .I_BITS  (CAP_I_BITS),
    .Q_BITS  (CAP_Q_BITS),
    .MAG_BITS(MAG_BITS)
  ) u_mag (
    .i_i  (in_i),
    .i_q  (in_q),
    .o_mag(w_mag)
  );

`ifdef CAPTURE_DECIM_EN
  assign w_decim = decim;
`else
  assign w_decim = 8'd0;
`endif

  assign w_sample = {in_i, in_q};
  // Held data stays put while the response window is full; only valid drops.
  assign w_wvalid = r_hold_valid && (r_outst != OUT_MAX);
  assign w_wr_acc = w_wvalid && cap.s_axi_cap_wready;
  assign w_b_acc  = cap.s_axi_cap_bvalid && r_bready;
  assign w_b_dec  = w_b_acc && (r_outst != '0);
  assign w_keep   = (r_dcnt == 8'd0);
  assign w_trig   = in_valid && ((w_mag >= threshold) || force_trig);
  assign w_in_acc = in_valid && w_in_ready;

  // Samples that decimation will drop never need the holding register.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_ARMED:   w_in_ready = 1'b1;
      ST_CAPTURE: w_in_ready = (r_loaded < LEN_CNT) &&
                               (!w_keep || !r_hold_valid || w_wr_acc);
      default:    w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold_valid <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_outst      <= '0;
      r_loaded     <= '0;
      r_decim      <= '0;
      r_dcnt       <= '0;
      r_bready     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      r_done   <= 1'b0;
      if (w_wr_acc && !w_b_dec)      r_outst <= r_outst + OUT_W'(1);
      else if (!w_wr_acc && w_b_dec) r_outst <= r_outst - OUT_W'(1);
      if (w_b_acc && cap.s_axi_cap_bresp) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state <= ST_ARMED;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_decim <= w_decim;
          end
        end
        ST_ARMED: begin
          if (w_trig) begin
            r_state      <= ST_CAPTURE;
            r_hold_valid <= 1'b1;
            r_wdata      <= w_sample;
            r_waddr      <= '0;
            r_loaded     <= LD_W'(1);
            r_dcnt       <= r_decim;
          end
        end
        ST_CAPTURE: begin
          if (w_in_acc && w_keep) begin
            r_hold_valid <= 1'b1;
            r_wdata      <= w_sample;
            r_loaded     <= r_loaded + LD_W'(1);
          end else if (w_wr_acc) begin
            r_hold_valid <= 1'b0;
          end
          if (w_in_acc) r_dcnt <= w_keep ? r_decim : r_dcnt - 8'd1;
          if (w_wr_acc) begin
            r_waddr <= r_waddr + CAP_INDEX_BITS'(1);
            if (r_waddr == LAST_ADDR) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_outst == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready             = w_in_ready;
  assign cap.m_axi_cap_waddr  = r_waddr;
  assign cap.m_axi_cap_wdata  = r_wdata;
  assign cap.m_axi_cap_wvalid = w_wvalid;
  assign cap.m_axi_cap_bready = r_bready;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign err                  = r_err;
endmodule

// File: doc/capture_writer.md
# capture_writer

Upstream feeder for `capture_buffer`. Accepts a streaming signed I/Q sample stream, waits for an arm command and an amplitude trigger, then writes exactly `CAP_BUFFER_LENGTH` consecutive samples into the capture buffer's write channel: address, data, ready/valid, and write-response handshake. It signals completion so the read-side logic can drain the buffer.

## Interface
- `CAP_I_BITS`, 12: I sample width, signed.
- `CAP_Q_BITS`, 12: Q sample width, signed.
- `CAP_INDEX_BITS`, 10: buffer address width.
- `CAP_BUFFER_LENGTH`, 1024: samples per capture, ≤ 2^`CAP_INDEX_BITS`.
- `OUTSTANDING_MAX`, 4: maximum accepted writes without a response.
- `MAG_BITS`, derived: max(`CAP_I_BITS`, `CAP_Q_BITS`) + 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `arm` in 1: one-cycle request to start a capture.
- `force_trig` in 1: trigger on the next accepted sample, regardless of magnitude.
- `threshold` in `MAG_BITS`: unsigned trigger level.
- `in_i` in `CAP_I_BITS`: sample I.
- `in_q` in `CAP_Q_BITS`: sample Q.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accepted when high with `in_valid`.
- `m_axi_cap_waddr` out `CAP_INDEX_BITS`: write address.
- `m_axi_cap_wdata` out `CAP_I_BITS+CAP_Q_BITS`: `{i, q}`, with I in the MSBs.
- `m_axi_cap_wvalid` out 1: write valid.
- `s_axi_cap_wready` in 1: write accepted.
- `s_axi_cap_bvalid` in 1: write response valid.
- `s_axi_cap_bresp` in 1: 1 means write error.
- `m_axi_cap_bready` out 1: response ready.
- `busy` out 1: high in ARMED, CAPTURE and DRAIN.
- `done` out 1: one-cycle pulse when a capture completes.
- `err` out 1: sticky; set on any response with `bresp`=1; cleared by `arm`.

## Operation
- FSM states are IDLE, ARMED, CAPTURE, DRAIN.
- **IDLE → ARMED** on `arm`. `arm` is ignored in every other state.
- **ARMED**
  - `in_ready`=1; samples are consumed and discarded.
  - mag = |in_i| + |in_q|, computed unsigned in `MAG_BITS`. The most-negative input maps to 2^(N-1) exactly.
  - Trigger condition: (`in_valid` and (mag ≥ `threshold` or `force_trig`)). On trigger, the sample is loaded into the holding register at address 0 and the FSM goes to CAPTURE.
  - `threshold`=0 triggers on the first valid sample.
- **CAPTURE**
  - A one-entry holding register drives `wdata`/`wvalid`.
  - `in_ready` = !hold_valid or (wvalid and wready), until `CAP_BUFFER_LENGTH` samples have been accepted.
  - Address increments by 1 on each accepted write (wvalid and wready).
  - After the write at address `CAP_BUFFER_LENGTH`-1 is accepted, the FSM goes to DRAIN and `in_ready`=0.
- **Outstanding writes**
  - The counter increments on an accepted write and decrements on bvalid and bready. A simultaneous increment and decrement leaves it unchanged.
  - When the counter equals `OUTSTANDING_MAX`, `wvalid` is forced low and the held data is kept.
- **DRAIN → IDLE** when the counter is 0; `done` pulses for 1 cycle at that transition.
- `m_axi_cap_bready` is 1 in every state out of reset.
- `wvalid` and `wdata` stay stable while waiting for `wready`.

## Timing
- Reset values:
  - `in_ready`=0, `wvalid`=0, `waddr`=0, `wdata`=0.
  - `bready`=0; it goes to 1 on the first clock after reset release.
  - `busy`=0, `done`=0, `err`=0, FSM=IDLE.
- `arm` sampled at edge t: `busy`=1 and `in_ready`=1 from t+1.
- Trigger sample accepted at edge t: `wvalid`=1 with `waddr`=0 from t+1.
- Steady state with `wready`=1 and `in_valid`=1: one write per cycle.
- `done` occurs at the earliest one cycle after the final response.
- `rst_n` low mid-capture: immediate return to reset values. Partial writes are abandoned and no `done` pulse is produced.

## Configuration
- `CAPTURE_DECIM_EN`
  - **Defined:** adds port `decim` in 8. In CAPTURE, only every (`decim`+1)-th accepted input sample is written; the trigger sample is always written. Discarded samples still assert `in_ready`. `decim` is sampled at arm.
  - **Undefined:** the port is absent and every accepted sample is written.

## Structure
- `capture_pkg`: FSM state enum and a `mag_bits` function.
- Sub-module `iq_magnitude`: combinational |i|+|q| for the trigger comparison.

## Test plan
- Arm, `threshold`=100, inputs (10,10), then (60,-50) → trigger on (60,-50); the first write is `waddr`=0 with `wdata`={60,-50}; `CAP_BUFFER_LENGTH` writes follow; `done` pulses once.
- `wready` toggled 1/0 every cycle → `wdata`/`wvalid` held stable while low; addresses 0..LEN-1 with no gaps or duplicates.
- `bvalid` withheld, `OUTSTANDING_MAX`=4 → exactly 4 accepted writes, then `wvalid`=0 until a response arrives.
- `bresp`=1 on write 5 → `err`=1 persists after `done` and clears on the next `arm`.
- `rst_n` pulsed low at write 300 → all outputs at reset values on the next cycle; no `done`.
- With `CAPTURE_DECIM_EN`, `decim`=3, input ramp 0,1,2,… with trigger at 0 → written I values 0,4,8,….
